lsu64: RTL



---
 rtl/lsu64_pkg.sv | 32 +++
 rtl/lsu64_extend.sv | 23 ++
 rtl/lsu64.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu64_pkg.sv
// Shared constants, state encoding and funct3 decode helpers for the lsu64 load/store unit.
package lsu64_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    // Stores have no unsigned forms; 111 is never a valid width.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? !f3[2] : (f3 != 3'b111);
    endfunction

endpackage

// File: rtl/lsu64_extend.sv
// RV64 load-result extension: sign-extends signed sub-doubleword loads, zero-extends unsigned ones.
module lsu64_extend
    import lsu64_pkg::*;
(
    input  logic [63:0] i_raw,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_funct3)
            F3_LB:   o_ext = {{56{i_raw[7]}},  i_raw[7:0]};
            F3_LH:   o_ext = {{48{i_raw[15]}}, i_raw[15:0]};
            F3_LW:   o_ext = {{32{i_raw[31]}}, i_raw[31:0]};
            F3_LBU:  o_ext = {56'd0, i_raw[7:0]};
            F3_LHU:  o_ext = {48'd0, i_raw[15:0]};
            F3_LWU:  o_ext = {32'd0, i_raw[31:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/lsu64.sv
// Single-outstanding load/store unit driving a 64-bit byte-addressable data memory port;
// misaligned accesses are either split into byte accesses or faulted.
module lsu64
    import lsu64_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic        memread,
    output logic        memwrite,
    output logic [2:0]  funct3,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    input  logic [63:0] rdata
);

    lsu_state_t  r_state;
    logic        r_we;
    logic        r_fault;
    logic [2:0]  r_f3;
    logic [2:0]  r_idx;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_raw;
    logic [63:0] r_rdata;

    logic [3:0]  w_req_size;
    logic        w_req_mis;
    logic [3:0]  w_size;
    logic        w_last;
    logic [7:0]  w_wbyte;
    logic [63:0] w_raw_nxt;
    logic [63:0] w_ext;
    logic        w_acc;
    logic        w_spl;

    assign w_req_size = f3_size(req_funct3);
    assign w_req_mis  = |(req_addr[3:0] & (w_req_size - 4'd1));
    assign w_size     = f3_size(r_f3);
    assign w_last     = ({1'b0, r_idx} == (w_size - 4'd1));
    assign w_wbyte    = r_wdata[{r_idx, 3'b000} +: 8];

    // Split loads assemble the result one lane at a time; aligned loads take rdata whole.
    always_comb begin
        w_raw_nxt = rdata;
        if (r_state == ST_SPLIT) begin
            w_raw_nxt = r_raw;
            w_raw_nxt[{r_idx, 3'b000} +: 8] = rdata[7:0];
        end
    end

    lsu64_extend u_extend (
        .i_raw    (w_raw_nxt),
        .i_funct3 (r_f3),
        .o_ext    (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            r_f3    <= 3'd0;
            r_idx   <= 3'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_raw   <= 64'd0;
            r_rdata <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_f3    <= req_funct3;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_idx   <= 3'd0;
                    r_raw   <= 64'd0;
                    r_rdata <= 64'd0;
                    r_fault <= 1'b0;
                    if (!f3_legal(req_we, req_funct3) || (w_req_mis && !SPLIT_MISALIGNED)) begin
                        r_fault <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (w_req_mis) begin
                        r_state <= ST_SPLIT;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_we ? 64'd0 : w_ext;
                    r_state <= ST_RESP;
                end
                ST_SPLIT: begin
                    r_raw <= w_raw_nxt;
                    r_idx <= r_idx + 3'd1;
                    if (w_last) begin
                        r_rdata <= r_we ? 64'd0 : w_ext;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rdata <= 64'd0;
                    r_fault <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_acc = (r_state == ST_ACCESS);
    assign w_spl = (r_state == ST_SPLIT);

    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = r_rdata;
    assign memread    = (w_acc || w_spl) && !r_we;
    assign memwrite   = (w_acc || w_spl) && r_we;
    assign funct3     = w_acc ? r_f3 : 3'd0;
    assign addr       = w_acc ? r_addr : (w_spl ? r_addr + {61'd0, r_idx} : 64'd0);
    assign wdata      = w_acc ? r_wdata : (w_spl ? {56'd0, w_wbyte} : 64'd0);

endmodule
